// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: write-port arbiter in front of the GRF.
// Merges the W-stage retirement write (fixed highest priority, combinational)
// with mult/div results that arrive through a valid/ready handshake and are
// buffered in a small circular FIFO. Exports a mask of registers targeted by
// queued entries so the hazard unit can stall readers of them.
//
// Optional feature macro: GRF_WB_DISPLAY_EN
//   defined   -> prints "$<reg> <= <data>" on every edge where a GRF write occurs
//   undefined -> no simulation output; the logic is the same either way.
module grf_wb_arbiter #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_waddr,
    input  logic [31:0] pipe_wdata,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_waddr,
    input  logic [31:0] md_wdata,
    output logic        RegWrite,
    output logic [4:0]  Waddr,
    output logic [31:0] WData,
    output logic [31:0] md_pending
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] LP_DEPTH = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0] LP_ONE   = (AW + 1)'(1);

    // Entry storage; kept in flops because the head must be readable in the
    // same cycle it is presented to the GRF.
    logic [4:0]            r_addr_mem [FIFO_DEPTH];
    logic [31:0]           r_data_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_valid;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW-1:0]         r_wr_ptr;
    logic [AW:0]           r_count;

    logic        w_pipe_act;
    logic        w_not_empty;
    logic        w_not_full;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_slot_mask [FIFO_DEPTH];

    assign w_pipe_act  = pipe_we && (pipe_waddr != 5'd0);
    assign w_not_empty = (r_count != '0);
    assign w_not_full  = (r_count < LP_DEPTH);

    // Ready depends only on reset and occupancy, never on md_valid.
    assign md_ready = !reset && w_not_full;

    // Writes to $0 complete the handshake but are dropped here.
    assign w_push = md_valid && md_ready && (md_waddr != 5'd0);

    // The FIFO only drains when the pipe leaves the write port free.
    assign w_pop = !reset && !w_pipe_act && w_not_empty;

    // Fixed-priority write-port mux: pipe first, then FIFO head, else idle.
    always_comb begin
        RegWrite = 1'b0;
        Waddr    = 5'd0;
        WData    = 32'd0;
        if (!reset) begin
            if (w_pipe_act) begin
                RegWrite = 1'b1;
                Waddr    = pipe_waddr;
                WData    = pipe_wdata;
            end else if (w_not_empty) begin
                RegWrite = 1'b1;
                Waddr    = r_addr_mem[r_rd_ptr];
                WData    = r_data_mem[r_rd_ptr];
            end
        end
    end

    // One-hot decode of each occupied slot's destination register.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot_mask
            assign w_slot_mask[gi] = r_valid[gi] ? (32'd1 << r_addr_mem[gi]) : 32'd0;
        end
    endgenerate

    // Pending mask is the OR of all occupied slot decodes (registered state only).
    always_comb begin
        md_pending = 32'd0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            md_pending = md_pending | w_slot_mask[i];
        end
    end

    // FIFO state: push at the tail, pop at the head, both may occur together.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_addr_mem[i] <= 5'd0;
                r_data_mem[i] <= 32'd0;
            end
        end else begin
            if (w_push) begin
                r_addr_mem[r_wr_ptr] <= md_waddr;
                r_data_mem[r_wr_ptr] <= md_wdata;
                r_valid[r_wr_ptr]    <= 1'b1;
                r_wr_ptr             <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LP_ONE;
                2'b01:   r_count <= r_count - LP_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef GRF_WB_DISPLAY_EN
    // Trace of every committed GRF write (replaces the GRF's own print).
    always_ff @(posedge clk) begin
        if (RegWrite && !reset) begin
            $display("$%d <= %h", Waddr, WData);
        end
    end
`endif

endmodule

// File: doc/grf_wb_arbiter.md
# grf_wb_arbiter

Write-port arbiter in front of the general register file (GRF) in the 5-stage MIPS pipeline. It is the producer side of the GRF write port, merging two writers: the W-stage retirement write (single-cycle, always accepted) and results from the multi-cycle mult/div unit (valid/ready handshake, buffered in a small FIFO). It drives the GRF `RegWrite`/`Waddr`/`WData` inputs. It also exports a pending-write mask so the hazard unit can stall readers of registers whose mult/div results are still queued.

## Interface
- `FIFO_DEPTH`, 4: mult/div entries buffered; power of 2, ≥2.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `pipe_we` in 1: W-stage write request.
- `pipe_waddr` in 5: W-stage destination register.
- `pipe_wdata` in 32: W-stage write data.
- `md_valid` in 1: mult/div result offered.
- `md_ready` out 1: arbiter can accept a result.
- `md_waddr` in 5: mult/div destination register.
- `md_wdata` in 32: mult/div result data.
- `RegWrite` out 1: GRF write enable.
- `Waddr` out 5: GRF write address.
- `WData` out 32: GRF write data.
- `md_pending` out 32: bit r = 1 when a queued FIFO entry targets register r.

## Operation
- **Effective pipe request:** `pipe_act = pipe_we && pipe_waddr != 0`.
- **Handshake:** an entry transfers on a rising edge where `md_valid && md_ready`.
  - `md_ready = !reset && count < FIFO_DEPTH`.
  - A transfer with `md_waddr == 0` is accepted but discarded, not enqueued.
- **FIFO state:**
  - Circular buffer holding {waddr, wdata}, with read pointer, write pointer and `count` (0..FIFO_DEPTH).
  - Pointers wrap modulo FIFO_DEPTH.
- **Arbitration, fixed priority with pipe highest:**
  - If `pipe_act`: `RegWrite=1`, `Waddr=pipe_waddr`, `WData=pipe_wdata`. The FIFO holds.
  - Else if `count > 0`: `RegWrite=1`, `Waddr`/`WData` = FIFO head, and the head pops at the edge.
  - Else: `RegWrite=0`, `Waddr=0`, `WData=0`.
- **Push and pop in the same cycle:** allowed when not full. `count` is unchanged and both pointers advance.
- **Full FIFO:** `md_ready=0`, so no push. A pop that cycle frees a slot visible next cycle; there is no same-cycle pass-through.
- **Ordering:** FIFO entries are written in arrival order.
  - A pipe write and a queued entry to the same register are written pipe-first, then the queued entry.
  - Preventing that case is the hazard unit's job, using `md_pending`.
- **Starvation:** the FIFO may starve while the pipe writes every cycle. This is permitted; the hazard unit uses `md_pending` to insert bubbles.
- **`md_pending`:** OR of one-hot decodes of the waddr of every valid stored entry.
  - It is a function of registered state only; the incoming `md_waddr` is not included.
  - It updates the cycle after a push or pop.

## Timing
- **Pipe path:** combinational, zero latency. `pipe_*` in cycle t drives the GRF in cycle t and the GRF updates at the end of t, which preserves existing W-stage timing.
- **Mult/div path:** minimum latency 1 cycle. A handshake at the end of cycle t puts the entry at the head in t+1; with the pipe idle it is written at the end of t+1.
- **`md_ready`:** a function of `count` only, with no combinational path from `md_valid`.
- **Reset:** while `reset=1`:
  - `RegWrite=0`, `Waddr=0`, `WData=0`, `md_ready=0`.
  - At the edge, count, pointers and entries clear, so `md_pending=0` from the next cycle.
  - Reset mid-operation drops all queued entries; no GRF write occurs in any reset cycle.
- **Out of reset:** `md_ready=1` in the first cycle after `reset` falls.

## Configuration
- `GRF_WB_DISPLAY_EN`:
  - **Defined:** on every rising edge with `RegWrite=1 && !reset`, the block prints `$display("$%d <= %h", Waddr, WData)`. The GRF's own print must then be disabled to avoid duplicate lines.
  - **Undefined:** no simulation output; the synthesized logic is identical.

## Test plan
- **Pipe only:** pipe_we=1, waddr=8, wdata=0x12345678 for one cycle → RegWrite=1, Waddr=8, WData=0x12345678 in the same cycle; FIFO untouched.
- **Mult/div when idle:** md push {9, 0xDEADBEEF} at edge t, pipe idle → md_pending[9]=1 in t+1 and GRF write in t+1; md_pending=0 in t+2.
- **Priority:** push {10, 0xA}; pipe writes reg 3 for 3 consecutive cycles → reg 10 is written only in the first cycle with pipe_we=0; md_pending[10] stays 1 until then.
- **Full / wrap:** with pipe busy, push 4 entries (regs 1–4) → md_ready=0, md_pending=0x1E. Release the pipe and push reg 5 during the drain → writes in order 1,2,3,4,5, and pointers wrap.
- **$0 discard:** push {0, 0xFFFF} and pipe_we=1 with waddr=0 → no RegWrite, count unchanged, md_pending=0.
- **Reset mid-operation:** 3 queued entries, assert reset 1 cycle → RegWrite=0 during reset, md_pending=0 and md_ready=1 after, and none of the dropped entries are ever written.
